layer2_mac: RTL

- Downstream stage of the first hidden layer.
- Consumes the serialized neuron outputs that layer presents one per valid cycle.
- Performs a sequential multiply-accumulate against a writable weight table, adds a bias and applies a ReLU activation, producing one 32-bit result per frame with a one-cycle done pulse.
- Data format: signed fixed point Q(32-FRAC).FRAC throughout.

---
 rtl/layer2_mac_if.sv | 27 ++
 rtl/layer2_mac.sv | 126 ++++++++++++
 2 files changed

// File: rtl/layer2_mac_if.sv
// Bus interface for layer2_mac: serialized neuron input stream, weight/bias
// write port and the activated result with its done pulse.
//   in_data/in_valid : upstream sample stream (driven by master)
//   w_we/w_addr/w_data : weight table write port (driven by master)
//   busy/out/done    : stage status and result (driven by slave)
interface layer2_mac_if #(
    parameter int unsigned AW = 2
) ();
    logic [31:0]   in_data;
    logic          in_valid;
    logic          busy;
    logic          w_we;
    logic [AW-1:0] w_addr;
    logic [31:0]   w_data;
    logic [31:0]   out;
    logic          done;

    modport master (
        output in_data, in_valid, w_we, w_addr, w_data,
        input  busy, out, done
    );

    modport slave (
        input  in_data, in_valid, w_we, w_addr, w_data,
        output busy, out, done
    );
endinterface

// File: rtl/layer2_mac.sv
// layer2_mac: second-layer neuron. Accumulates N_IN serial samples against a
// writable weight table (saturating Q(32-FRAC).FRAC MAC), adds a bias and
// applies ReLU, emitting one result per frame with a single-cycle done pulse.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : layer2_mac_if.slave (in_data/in_valid in, w_we/w_addr/w_data in,
//          busy/out/done out)
// Optional feature: define LAYER2_LEAKY_RELU_EN for a leaky ReLU (slope 1/8)
// instead of the plain ReLU.
module layer2_mac #(
    parameter int unsigned N_IN = 3,
    parameter int unsigned FRAC = 16,
    parameter int unsigned AW   = 2
) (
    input  logic        clk,
    input  logic        rst,
    layer2_mac_if.slave bus
);
    localparam int unsigned NW = N_IN + 1;
    localparam int unsigned CW = (N_IN > 1) ? $clog2(N_IN) : 1;

    typedef enum logic [1:0] {
        S_COLLECT,
        S_BIAS,
        S_ACT
    } state_e;

    state_e             state_q;
    logic [CW-1:0]      cnt_q;
    logic signed [31:0] acc_q;
    logic signed [31:0] out_q;
    logic               done_q;
    logic               busy_q;
    logic signed [31:0] w_q [NW];

    logic signed [31:0] w_rd;
    logic signed [63:0] prod;
    logic signed [31:0] mac_d;
    logic signed [31:0] bias_d;
    logic signed [31:0] act_d;

    // Clamp a 64-bit signed value into the signed 32-bit range.
    function automatic logic signed [31:0] sat32(input logic signed [63:0] v);
        if (v > 64'sh0000_0000_7FFF_FFFF) begin
            return 32'sh7FFF_FFFF;
        end else if (v < -64'sh0000_0000_8000_0000) begin
            return 32'sh8000_0000;
        end else begin
            return v[31:0];
        end
    endfunction

    // Datapath: product scaled back to the fixed-point grid, then saturating adds.
    always_comb begin
        w_rd   = w_q[AW'(cnt_q)];
        prod   = 64'($signed(bus.in_data)) * 64'(w_rd);
        mac_d  = sat32(64'(acc_q) + 64'(sat32(prod >>> FRAC)));
        bias_d = sat32(64'(acc_q) + 64'(w_q[N_IN]));
`ifdef LAYER2_LEAKY_RELU_EN
        act_d  = acc_q[31] ? (acc_q >>> 3) : acc_q;
`else
        act_d  = acc_q[31] ? 32'sd0 : acc_q;
`endif
    end

    // Control FSM, weight table and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_COLLECT;
            cnt_q   <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            for (int unsigned i = 0; i < NW; i++) begin
                w_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;

            // Writes land at the edge, so a same-cycle sample still sees the old weight.
            if (bus.w_we) begin
                for (int unsigned i = 0; i < NW; i++) begin
                    if (bus.w_addr == AW'(i)) begin
                        w_q[i] <= bus.w_data;
                    end
                end
            end

            case (state_q)
                S_COLLECT: begin
                    if (bus.in_valid) begin
                        acc_q <= mac_d;
                        if (cnt_q == CW'(N_IN - 1)) begin
                            cnt_q   <= '0;
                            state_q <= S_BIAS;
                            busy_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                S_BIAS: begin
                    acc_q   <= bias_d;
                    state_q <= S_ACT;
                end
                S_ACT: begin
                    out_q   <= act_d;
                    done_q  <= 1'b1;
                    acc_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= S_COLLECT;
                end
                default: begin
                    state_q <= S_COLLECT;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.out  = out_q;
    assign bus.done = done_q;
endmodule
